// File: rtl/histogram_reader.sv
// histogram_reader: walks every bin of a histogram RAM, streams (bin, count) beats
// and keeps a running total and peak.  Define HIST_READ_CLEAR_EN for clear-on-read.
module histogram_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 7
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [ADDR_W-1:0]        mem_adr,
    output logic                     mem_wren,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_bin,
    output logic [DATA_W-1:0]        out_count,
    output logic                     out_last,
    output logic [DATA_W+ADDR_W-1:0] total,
    output logic [ADDR_W-1:0]        max_bin,
    output logic [DATA_W-1:0]        max_count
);

    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_CAPT  = 3'd3,
`ifdef HIST_READ_CLEAR_EN
        CLR      = 3'd4,
`endif
        PRESENT  = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] k;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = RD_ISSUE;
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = RD_CAPT;
`ifdef HIST_READ_CLEAR_EN
            RD_CAPT:  next_state = CLR;
            CLR:      next_state = PRESENT;
`else
            RD_CAPT:  next_state = PRESENT;
`endif
            PRESENT: begin
                if (out_ready) begin
                    next_state = (k == LAST_BIN) ? FIN : RD_ISSUE;
                end
            end
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);
    assign out_valid = (state == PRESENT);
    assign mem_wdata = '0;

`ifdef HIST_READ_CLEAR_EN
    // Write strobe covers exactly the CLR cycle, with mem_adr still holding k.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_wren <= 1'b0;
        end else begin
            mem_wren <= (state == RD_CAPT);
        end
    end
`else
    assign mem_wren = 1'b0;
`endif

    // The RAM address advances only on a completed handshake, so it is stable for the whole bin.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k         <= '0;
            mem_adr   <= '0;
            out_bin   <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            total     <= '0;
            max_bin   <= '0;
            max_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_adr <= '0;
                    if (START) begin
                        k         <= '0;
                        total     <= '0;
                        max_bin   <= '0;
                        max_count <= '0;
                    end
                end
                RD_CAPT: begin
                    out_bin   <= k;
                    out_count <= mem_q;
                    out_last  <= (k == LAST_BIN);
                    total     <= total + {{ADDR_W{1'b0}}, mem_q};
                    // Strict compare keeps the lowest bin on ties.
                    if (mem_q > max_count) begin
                        max_count <= mem_q;
                        max_bin   <= k;
                    end
                end
                PRESENT: begin
                    if (out_ready && (k != LAST_BIN)) begin
                        k       <= k + 1'b1;
                        mem_adr <= k + 1'b1;
                    end
                end
                FIN: begin
                    mem_adr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_reader.sv
// Directed bench for histogram_reader with a two-cycle-latency RAM model.
module tb_histogram_reader;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 7;
    localparam int NB     = 128;
`ifdef HIST_READ_CLEAR_EN
    localparam int PER_BIN = 5;
    localparam bit CLEARS  = 1'b1;
`else
    localparam int PER_BIN = 4;
    localparam bit CLEARS  = 1'b0;
`endif

    logic                     CLK = 1'b0;
    logic                     RST_N;
    logic                     START;
    logic                     BUSY;
    logic                     DONE;
    logic [ADDR_W-1:0]        mem_adr;
    logic                     mem_wren;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_q;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_bin;
    logic [DATA_W-1:0]        out_count;
    logic                     out_last;
    logic [DATA_W+ADDR_W-1:0] total;
    logic [ADDR_W-1:0]        max_bin;
    logic [DATA_W-1:0]        max_count;

    int checks = 0;
    int passes = 0;
    int exp_ram [NB];

    logic [DATA_W-1:0] ram [NB];
    logic [ADDR_W-1:0] ram_adr_q;
    logic              load_en = 1'b0;
    int                load_val = 0;

    histogram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
        .mem_adr(mem_adr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_count(out_count), .out_last(out_last), .total(total),
        .max_bin(max_bin), .max_count(max_count)
    );

    always #5 CLK = ~CLK;

    // Registered address then registered output: data valid two cycles after the address.
    always @(posedge CLK) begin
        ram_adr_q <= mem_adr;
        mem_q     <= ram[ram_adr_q];
        if (load_en) begin
            for (int i = 0; i < NB; i++) begin
                ram[i] <= (load_val < 0) ? DATA_W'(i) : DATA_W'(load_val);
            end
        end else if (mem_wren) begin
            ram[mem_adr] <= mem_wdata;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load_ram(input int v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge CLK);
        load_en  = 1'b0;
        for (int i = 0; i < NB; i++) exp_ram[i] = (v < 0) ? i : v;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},      32'(BUSY),      0);
        check_output({tag, "_done"},      32'(DONE),      0);
        check_output({tag, "_mem_adr"},   32'(mem_adr),   0);
        check_output({tag, "_mem_wren"},  32'(mem_wren),  0);
        check_output({tag, "_out_valid"}, 32'(out_valid), 0);
        check_output({tag, "_out_bin"},   32'(out_bin),   0);
        check_output({tag, "_out_count"}, 32'(out_count), 0);
        check_output({tag, "_out_last"},  32'(out_last),  0);
        check_output({tag, "_total"},     32'(total),     0);
        check_output({tag, "_max_bin"},   32'(max_bin),   0);
        check_output({tag, "_max_count"}, 32'(max_count), 0);
    endtask

    // One full dump; expected values come from exp_ram.
    task automatic apply_stimulus(input string tag, input int stall_bin, input int stall_cycles,
                                  input bit repulse);
        int cyc, beat, stall_left, extra, exp_total, exp_max_bin, exp_max_count;
        bit done_seen;
        exp_total = 0; exp_max_bin = 0; exp_max_count = 0;
        for (int i = 0; i < NB; i++) begin
            exp_total += exp_ram[i];
            if (exp_ram[i] > exp_max_count) begin
                exp_max_count = exp_ram[i];
                exp_max_bin   = i;
            end
        end
        cyc = 0; beat = 0; stall_left = stall_cycles; done_seen = 1'b0;
        START = 1'b1;
        out_ready = 1'b1;
        while (!done_seen && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
            START = repulse && (cyc >= 20) && (cyc < 23);
            if (cyc == 1) check_output({tag, "_busy_start"}, 32'(BUSY), 1);
            if (DONE) begin
                done_seen = 1'b1;
            end else if (out_valid) begin
                if (beat == stall_bin && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check_output({tag, "_stall_bin"},   32'(out_bin),   32'(stall_bin));
                    check_output({tag, "_stall_count"}, 32'(out_count), 32'(exp_ram[stall_bin]));
                    check_output({tag, "_stall_adr"},   32'(mem_adr),   32'(stall_bin));
                end else begin
                    out_ready = 1'b1;
                    if (beat < NB) begin
                        check_output({tag, "_bin"},   32'(out_bin),   32'(beat));
                        check_output({tag, "_count"}, 32'(out_count), 32'(exp_ram[beat]));
                        check_output({tag, "_last"},  32'(out_last),  32'(beat == NB - 1));
                        check_output({tag, "_adr"},   32'(mem_adr),   32'(beat));
                    end else begin
                        check_output({tag, "_beat_overrun"}, 32'(beat), 32'(NB - 1));
                    end
                    beat++;
                end
            end
        end
        START = 1'b0;
        out_ready = 1'b1;
        check_output({tag, "_done_seen"},  32'(done_seen), 1);
        check_output({tag, "_done_cycle"}, 32'(cyc), 32'(NB * PER_BIN + stall_cycles + 1));
        check_output({tag, "_beats"},      32'(beat), 32'(NB));
        check_output({tag, "_total"},      32'(total), 32'(exp_total));
        check_output({tag, "_max_bin"},    32'(max_bin), 32'(exp_max_bin));
        check_output({tag, "_max_count"},  32'(max_count), 32'(exp_max_count));
        @(negedge CLK);
        check_output({tag, "_done_pulse"}, 32'(DONE), 0);
        check_output({tag, "_busy_end"},   32'(BUSY), 0);
        check_output({tag, "_idle_adr"},   32'(mem_adr), 0);
        extra = 0;
        repeat (20) begin
            @(negedge CLK);
            if (out_valid || BUSY || DONE) extra++;
        end
        check_output({tag, "_no_second_dump"}, 32'(extra), 0);
        check_output({tag, "_total_held"},     32'(total), 32'(exp_total));
        check_output({tag, "_max_held"},       32'(max_count), 32'(exp_max_count));
        if (CLEARS) begin
            for (int i = 0; i < NB; i++) exp_ram[i] = 0;
        end
    endtask

    initial begin
        int cyc;
        bit found;
        RST_N = 1'b0;
        START = 1'b0;
        out_ready = 1'b1;
        load_ram(-1);
        @(negedge CLK);
        check_all_zero("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        $display("[TB] ramp dump, then repeat dump");
        apply_stimulus("ramp", -1, 0, 1'b0);
        apply_stimulus("second", -1, 0, 1'b0);

        $display("[TB] backpressure at bin 5");
        load_ram(-1);
        apply_stimulus("stall", 5, 10, 1'b0);

        $display("[TB] flat bins with START re-pulsed while busy");
        load_ram(3);
        apply_stimulus("flat", -1, 0, 1'b1);

        $display("[TB] reset during bin 40");
        load_ram(-1);
        START = 1'b1;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            START = 1'b0;
            if (mem_adr == 7'd40) found = 1'b1;
        end
        check_output("midreset_reach_bin40", 32'(found), 1);
        RST_N = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        if (CLEARS) begin
            for (int i = 0; i < 40; i++) exp_ram[i] = 0;
        end
        @(negedge CLK);
        apply_stimulus("after_reset", -1, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
